// File: rtl/multicycle_control.sv
// multicycle_control: IF/ID/EX/MEM/WB control FSM for the multi-cycle MIPS datapath.
// Define MC_INTERRUPT_EN to add irq/irq_ack/EPCWrite and the one-cycle IRQ state.
module multicycle_control #(
    parameter int         MEM_WAIT_MAX = 16,
    parameter logic [1:0] EXC_PCSRC    = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
`ifdef MC_INTERRUPT_EN
    input  logic       irq,
    output logic       irq_ack,
    output logic       EPCWrite,
`endif
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic       LuOp,
    output logic [5:0] ALUFun,
    output logic       illegal_op,
    output logic       bus_error
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd5, S_IRQ = 3'd6
    } state_t;

    localparam logic [5:0] ALU_ADD = 6'b000000, ALU_SUB = 6'b000001, ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110, ALU_XOR = 6'b010110, ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000, ALU_SRL = 6'b100001, ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011, ALU_NE  = 6'b110001, ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101, ALU_GTZ = 6'b111011, ALU_LTZ = 6'b111111;
    localparam logic [1:0] JR_PCSRC  = 2'd3;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d, bus_q, bus_d;
    logic [5:0] r_alu, op_alu;
    logic       r_ok, op_ok, waiting, timeout, irq_take;
    logic       is_r, is_j, is_jal, is_jr, is_jalr, is_jump, is_br, is_lw, is_sw, is_iarith, is_shift;

    assign is_r      = OpCode == 6'h00;
    assign is_j      = OpCode == 6'h02;
    assign is_jal    = OpCode == 6'h03;
    assign is_jr     = is_r && Funct == 6'h08;
    assign is_jalr   = is_r && Funct == 6'h09;
    assign is_jump   = is_j || is_jal || is_jr || is_jalr;
    assign is_br     = OpCode == 6'h01 || OpCode[5:2] == 4'b0001;
    assign is_lw     = OpCode == 6'h23;
    assign is_sw     = OpCode == 6'h2B;
    assign is_iarith = OpCode[5:3] == 3'b001;
    assign is_shift  = is_r && (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03);
    assign waiting   = (state_q == S_IF || state_q == S_MEM) && !mem_ready;
`ifdef MC_INTERRUPT_EN
    assign irq_take  = state_q == S_IF && irq && cnt_q == 8'd0;
`else
    assign irq_take  = 1'b0;
`endif
    assign timeout   = waiting && !irq_take && cnt_q == WAIT_LAST;
    assign illegal_op = illegal_q;
    assign bus_error  = bus_q;

    always_comb begin
        r_alu = ALU_ADD;
        r_ok  = 1'b1;
        case (Funct)
            6'h00: r_alu = ALU_SLL;
            6'h02: r_alu = ALU_SRL;
            6'h03: r_alu = ALU_SRA;
            6'h08, 6'h09, 6'h20, 6'h21: r_alu = ALU_ADD;
            6'h22, 6'h23: r_alu = ALU_SUB;
            6'h24: r_alu = ALU_AND;
            6'h25: r_alu = ALU_OR;
            6'h26: r_alu = ALU_XOR;
            6'h27: r_alu = ALU_NOR;
            6'h2A, 6'h2B: r_alu = ALU_LT;
            default: r_ok = 1'b0;
        endcase
        op_alu = ALU_ADD;
        op_ok  = 1'b1;
        case (OpCode)
            6'h00: begin
                op_alu = r_alu;
                op_ok  = r_ok;
            end
            6'h01: op_alu = ALU_LTZ;
            6'h04: op_alu = ALU_EQ;
            6'h05: op_alu = ALU_NE;
            6'h06: op_alu = ALU_LEZ;
            6'h07: op_alu = ALU_GTZ;
            6'h02, 6'h03, 6'h08, 6'h09, 6'h0F, 6'h23, 6'h2B: op_alu = ALU_ADD;
            6'h0A, 6'h0B: op_alu = ALU_LT;
            6'h0C: op_alu = ALU_AND;
            6'h0D: op_alu = ALU_OR;
            6'h0E: op_alu = ALU_XOR;
            default: op_ok = 1'b0;
        endcase
    end

    // Outputs are decoded from state and inputs so the memory handshake acts in the same cycle.
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = 2'd0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'd0;
        MemtoReg    = 2'd0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 2'd0;
        ExtOp       = 1'b0;
        LuOp        = 1'b0;
        ALUFun      = ALU_ADD;
`ifdef MC_INTERRUPT_EN
        irq_ack     = 1'b0;
        EPCWrite    = 1'b0;
`endif
        if (reset) begin
            case (state_q)
                S_IF: begin
                    ALUSrcB = 2'd1;
                    MemRead = !irq_take;
                    IRWrite = mem_ready && !irq_take;
                    PCWrite = mem_ready && !irq_take;
                    state_d = irq_take ? S_IRQ : mem_ready ? S_ID : timeout ? S_ERR : S_IF;
                end
                S_ID: begin
                    ALUSrcB  = 2'd3;
                    ExtOp    = 1'b1;
                    PCWrite  = is_jump;
                    PCSrc    = (is_jr || is_jalr) ? JR_PCSRC : (is_j || is_jal) ? 2'd2 : 2'd0;
                    RegWrite = is_jal || is_jalr;
                    RegDst   = is_jal ? 2'd2 : is_jalr ? 2'd1 : 2'd0;
                    MemtoReg = (is_jal || is_jalr) ? 2'd2 : 2'd0;
                    state_d  = !op_ok ? S_ERR : is_jump ? S_IF : S_EX;
                end
                S_EX: begin
                    ALUFun      = op_alu;
                    ExtOp       = !(OpCode == 6'h0B || OpCode == 6'h0C || OpCode == 6'h0D);
                    LuOp        = OpCode == 6'h0F;
                    ALUSrcA     = is_shift ? 2'd2 : 2'd1;
                    ALUSrcB     = (is_r || is_br) ? 2'd0 : 2'd2;
                    PCWriteCond = is_br;
                    PCSrc       = is_br ? 2'd1 : 2'd0;
                    state_d     = (is_r || is_iarith) ? S_WB : (is_lw || is_sw) ? S_MEM : S_IF;
                end
                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = is_lw;
                    MemWrite = !is_lw;
                    state_d  = mem_ready ? (is_lw ? S_WB : S_IF) : timeout ? S_ERR : S_MEM;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = is_r ? 2'd1 : 2'd0;
                    MemtoReg = is_lw ? 2'd1 : 2'd0;
                    state_d  = S_IF;
                end
                S_IRQ: begin
                    PCWrite  = 1'b1;
                    PCSrc    = EXC_PCSRC;
`ifdef MC_INTERRUPT_EN
                    irq_ack  = 1'b1;
                    EPCWrite = 1'b1;
`endif
                    state_d  = S_IF;
                end
                S_ERR: state_d = S_ERR;
                default: state_d = S_IF;
            endcase
        end
        illegal_d = illegal_q || (state_q == S_ID && !op_ok);
        bus_d     = bus_q || timeout;
        cnt_d     = state_d != state_q ? 8'd0 : waiting ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IF;
            cnt_q     <= 8'd0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_q     <= bus_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven directed vectors plus hand sequences for waits, errors and reset.
module tb_multicycle_control;
    localparam logic O = 1'b0, I = 1'b1;
    localparam logic [1:0] D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3;
    localparam logic [5:0] ADD = 6'b000000, OR = 6'b011110, SLL = 6'b100000, EQ = 6'b110011;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [26:0] exp;
        string       name;
    } vec_t;

    logic clk, reset, mem_ready;
    logic [5:0] OpCode, Funct, ALUFun;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuOp;
    logic illegal_op, bus_error;
    logic [1:0] PCSrc, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
`ifdef MC_INTERRUPT_EN
    logic irq, irq_ack, EPCWrite;
`endif
    logic [26:0] act;
    int n_checks = 0, n_fail = 0;
    vec_t tv[$];
    logic [26:0] e_zero, e_if, e_ifw, e_id, e_rwb, e_iwb, e_mex;

    multicycle_control dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
`ifdef MC_INTERRUPT_EN
        .irq(irq), .irq_ack(irq_ack), .EPCWrite(EPCWrite),
`endif
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtOp(ExtOp), .LuOp(LuOp), .ALUFun(ALUFun), .illegal_op(illegal_op), .bus_error(bus_error)
    );

    assign act = {PCWrite, PCWriteCond, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
                  MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp, ALUFun, illegal_op, bus_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [26:0] ov(input logic pcw, pcwc, input logic [1:0] pcsrc,
                                       input logic iord, mr, mw, irw, rw,
                                       input logic [1:0] rd, m2r, sa, sb,
                                       input logic ext, lu, input logic [5:0] fun, input logic ill, be);
        return {pcw, pcwc, pcsrc, iord, mr, mw, irw, rw, rd, m2r, sa, sb, ext, lu, fun, ill, be};
    endfunction

    task automatic step(input logic r, input logic [5:0] op, fn, input logic rdy,
                        input logic [26:0] exp, input string name);
        @(negedge clk);
        reset = r;
        OpCode = op;
        Funct = fn;
        mem_ready = rdy;
        #2;
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic [5:0] op, fn, input logic [26:0] exp, input string name);
        tv.push_back('{I, op, fn, I, exp, name});
    endtask

    initial begin
        reset = 1'b0;
        OpCode = 6'h00;
        Funct = 6'h00;
        mem_ready = 1'b0;
`ifdef MC_INTERRUPT_EN
        irq = 1'b0;
`endif
        e_zero = ov(O,O,D0,O,O,O,O,O,D0,D0,D0,D0,O,O,ADD,O,O);
        e_if   = ov(I,O,D0,O,I,O,I,O,D0,D0,D0,D1,O,O,ADD,O,O);
        e_ifw  = ov(O,O,D0,O,I,O,O,O,D0,D0,D0,D1,O,O,ADD,O,O);
        e_id   = ov(O,O,D0,O,O,O,O,O,D0,D0,D0,D3,I,O,ADD,O,O);
        e_rwb  = ov(O,O,D0,O,O,O,O,I,D1,D0,D0,D0,O,O,ADD,O,O);
        e_iwb  = ov(O,O,D0,O,O,O,O,I,D0,D0,D0,D0,O,O,ADD,O,O);
        e_mex  = ov(O,O,D0,O,O,O,O,O,D0,D0,D1,D2,I,O,ADD,O,O);
        tv.push_back('{O, 6'h00, 6'h20, I, e_zero, "reset outputs"});
        v(6'h00, 6'h20, e_if, "add IF");
        v(6'h00, 6'h20, e_id, "add ID");
        v(6'h00, 6'h20, ov(O,O,D0,O,O,O,O,O,D0,D0,D1,D0,I,O,ADD,O,O), "add EX");
        v(6'h00, 6'h20, e_rwb, "add WB");
        v(6'h00, 6'h00, e_if, "sll IF");
        v(6'h00, 6'h00, e_id, "sll ID");
        v(6'h00, 6'h00, ov(O,O,D0,O,O,O,O,O,D0,D0,D2,D0,I,O,SLL,O,O), "sll EX");
        v(6'h00, 6'h00, e_rwb, "sll WB");
        v(6'h0D, 6'h00, e_if, "ori IF");
        v(6'h0D, 6'h00, e_id, "ori ID");
        v(6'h0D, 6'h00, ov(O,O,D0,O,O,O,O,O,D0,D0,D1,D2,O,O,OR,O,O), "ori EX");
        v(6'h0D, 6'h00, e_iwb, "ori WB");
        v(6'h0F, 6'h00, e_if, "lui IF");
        v(6'h0F, 6'h00, e_id, "lui ID");
        v(6'h0F, 6'h00, ov(O,O,D0,O,O,O,O,O,D0,D0,D1,D2,I,I,ADD,O,O), "lui EX");
        v(6'h0F, 6'h00, e_iwb, "lui WB");
        v(6'h04, 6'h00, e_if, "beq IF");
        v(6'h04, 6'h00, e_id, "beq ID");
        v(6'h04, 6'h00, ov(O,I,D1,O,O,O,O,O,D0,D0,D1,D0,I,O,EQ,O,O), "beq EX");
        v(6'h02, 6'h00, e_if, "j IF");
        v(6'h02, 6'h00, ov(I,O,D2,O,O,O,O,O,D0,D0,D0,D3,I,O,ADD,O,O), "j ID");
        v(6'h03, 6'h00, e_if, "jal IF");
        v(6'h03, 6'h00, ov(I,O,D2,O,O,O,O,I,D2,D2,D0,D3,I,O,ADD,O,O), "jal ID");
        v(6'h00, 6'h08, e_if, "jr IF");
        v(6'h00, 6'h08, ov(I,O,D3,O,O,O,O,O,D0,D0,D0,D3,I,O,ADD,O,O), "jr ID");
        v(6'h2B, 6'h00, e_if, "sw IF");
        v(6'h2B, 6'h00, e_id, "sw ID");
        v(6'h2B, 6'h00, e_mex, "sw EX");
        v(6'h2B, 6'h00, ov(O,O,D0,I,O,I,O,O,D0,D0,D0,D0,O,O,ADD,O,O), "sw MEM");

        @(posedge clk);
        foreach (tv[i]) step(tv[i].rst_n, tv[i].op, tv[i].fn, tv[i].rdy, tv[i].exp, tv[i].name);

        // lw with three wait states in MEM
        step(I, 6'h23, 6'h00, I, e_if, "lw IF");
        step(I, 6'h23, 6'h00, I, e_id, "lw ID");
        step(I, 6'h23, 6'h00, I, e_mex, "lw EX");
        for (int k = 0; k < 4; k++)
            step(I, 6'h23, 6'h00, k == 3, ov(O,O,D0,I,I,O,O,O,D0,D0,D0,D0,O,O,ADD,O,O), "lw MEM hold");
        step(I, 6'h23, 6'h00, I, ov(O,O,D0,O,O,O,O,I,D0,D1,D0,D0,O,O,ADD,O,O), "lw WB");

        // illegal opcode, sticky ERR, then one reset edge
        step(I, 6'h3F, 6'h00, I, e_if, "ill IF");
        step(I, 6'h3F, 6'h00, I, e_id, "ill ID");
        for (int k = 0; k < 3; k++)
            step(I, 6'h3F, 6'h00, I, ov(O,O,D0,O,O,O,O,O,D0,D0,D0,D0,O,O,ADD,I,O), "ill ERR");
        step(O, 6'h3F, 6'h00, I, ov(O,O,D0,O,O,O,O,O,D0,D0,D0,D0,O,O,ADD,I,O), "ill reset");

        // fetch never acknowledged: 16 wait cycles then bus_error
        for (int k = 0; k < 16; k++) step(I, 6'h00, 6'h20, O, e_ifw, "timeout wait");
        step(I, 6'h00, 6'h20, O, ov(O,O,D0,O,O,O,O,O,D0,D0,D0,D0,O,O,ADD,O,I), "timeout ERR");
        step(I, 6'h00, 6'h20, I, ov(O,O,D0,O,O,O,O,O,D0,D0,D0,D0,O,O,ADD,O,I), "timeout ERR hold");
        step(O, 6'h00, 6'h20, I, ov(O,O,D0,O,O,O,O,O,D0,D0,D0,D0,O,O,ADD,O,I), "bus reset");

        // mem_ready on the limit cycle wins over the timeout
        for (int k = 0; k < 15; k++) step(I, 6'h00, 6'h20, O, e_ifw, "limit wait");
        step(I, 6'h00, 6'h20, I, e_if, "limit ready");
        step(I, 6'h00, 6'h20, I, e_id, "limit ID");

`ifdef MC_INTERRUPT_EN
        step(O, 6'h00, 6'h20, I, e_zero, "irq reset");
        irq = 1'b1;
        step(I, 6'h00, 6'h20, I, ov(O,O,D0,O,O,O,O,O,D0,D0,D0,D1,O,O,ADD,O,O), "irq IF");
        irq = 1'b0;
        step(I, 6'h00, 6'h20, I, ov(I,O,D3,O,O,O,O,O,D0,D0,D0,D0,O,O,ADD,O,O), "irq IRQ");
        n_checks++;
        if ({irq_ack, EPCWrite} !== 2'b11) begin
            n_fail++;
            $display("FAIL irq ack: got %b expected 11", {irq_ack, EPCWrite});
        end
        step(I, 6'h00, 6'h20, I, e_if, "irq back IF");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
